// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the two-requester ALU arbiter
package alu_arb_pkg;

  localparam int ALU_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - combinational two-input round-robin picker
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  logic other;
  logic winner;

  always_comb begin
    other  = ~last_i;
    // Favour whichever requester did not win last time; fall back to the other.
    winner = req_i[other] ? other : last_i;
    gnt_o  = 2'b00;
    if (req_i[winner]) begin
      gnt_o[winner] = 1'b1;
    end
    gnt_id_o = winner;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one external ALU between two requesters
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_nz
);

  state_e           state_q, state_d;
  logic             last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;
  logic             nz_q;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic             fire;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_op;

  rr_arb2 u_rr_arb2 (
    .req_i    (req_valid),
    .last_i   (last_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign sel_a  = gnt_id ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
  assign sel_b  = gnt_id ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
  assign sel_op = req_op[gnt_id];
  assign fire   = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing looks acceptable while the block is held.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    if (state_q == IDLE && !reset) begin
      req_ready = gnt;
    end
    if (state_q == RESP) begin
      rsp_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= 1'b0;
      id_q   <= 1'b0;
      data_q <= '0;
      nz_q   <= 1'b0;
    end else begin
      if (fire) begin
        a_q    <= sel_a;
        b_q    <= sel_b;
        op_q   <= sel_op;
        last_q <= gnt_id;
        id_q   <= gnt_id;
      end
      if (state_q == EXEC) begin
        data_q <= alu_result;
        nz_q   <= ~alu_zf;
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_nz   = nz_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int W   = 7;
  localparam int MOD = 1 << W;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [1:0]     req_op;
  logic [W-1:0]   alu_a, alu_b, alu_result;
  logic           alu_op, alu_zf;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_nz;
  logic [W-1:0]   rsp_data;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zf     (alu_zf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_nz     (rsp_nz)
  );

  always #5 clk = ~clk;

  assign alu_result = (alu_op == OP_SUB) ? alu_a - alu_b : alu_a + alu_b;
  assign alu_zf     = (alu_result == '0);

  function automatic int ref_alu(input int a, input int b, input bit op);
    int r;
    r = op ? (a - b) : (a + b);
    return ((r % MOD) + MOD) % MOD;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit op);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_op[i]       = op;
  endtask

  task automatic wait_grant(input string name, input int exp_id, input int max_cycles);
    int n;
    n = 0;
    while (req_ready == 2'b00 && n < max_cycles) begin
      tick();
      n++;
    end
    if (req_ready == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within %0d cycles, expected req %0d", name, max_cycles, exp_id);
    end else begin
      check(name, 32'(req_ready), 32'(1 << exp_id));
    end
  endtask

  // Called in the EXEC cycle; leaves the bench in the first RESP cycle.
  task automatic expect_rsp(input string name, input int id, input int data, input bit nz);
    check({name, "_exec_valid"}, 32'(rsp_valid), 0);
    check({name, "_exec_ready"}, 32'(req_ready), 0);
    tick();
    check({name, "_valid"}, 32'(rsp_valid), 1);
    check({name, "_id"}, 32'(rsp_id), 32'(id));
    check({name, "_data"}, 32'(rsp_data), 32'(data));
    check({name, "_nz"}, 32'(rsp_nz), 32'(nz));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [1:0] valid;
    int a0, b0; bit op0;
    int a1, b1; bit op1;
    int exp_id, exp_data; bit exp_nz;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input int a0, input int b0, input bit op0,
                              input int a1, input int b1, input bit op1,
                              input int id, input int data, input bit nz);
    vec_t t;
    t.valid = v; t.a0 = a0; t.b0 = b0; t.op0 = op0;
    t.a1 = a1; t.b1 = b1; t.op1 = op1;
    t.exp_id = id; t.exp_data = data; t.exp_nz = nz;
    return t;
  endfunction

  vec_t vecs[7];

  initial begin
    int  w, m_last, m_id, m_data, phase, granted;
    bit  m_nz;
    bit  pend[2];
    int  pa[2], pb[2];
    bit  pop[2];

    vecs[0] = mk(2'b01,   5,  3, 1'b0,   0, 0, 1'b0, 0,   8, 1'b1);
    vecs[1] = mk(2'b10,   0,  0, 1'b0, 127, 1, 1'b0, 1,   0, 1'b0);
    vecs[2] = mk(2'b11,  10, 10, 1'b1,   2, 4, 1'b0, 0,   0, 1'b0);
    vecs[3] = mk(2'b11,  50, 50, 1'b0,   0, 1, 1'b1, 1, 127, 1'b1);
    vecs[4] = mk(2'b01, 100, 50, 1'b0,   0, 0, 1'b0, 0,  22, 1'b1);
    vecs[5] = mk(2'b10,   0,  0, 1'b0,   3, 5, 1'b1, 1, 126, 1'b1);
    vecs[6] = mk(2'b11,  64, 64, 1'b0,   1, 1, 1'b0, 0,   0, 1'b0);

    reset     = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    tick();
    check("reset_req_ready", 32'(req_ready), 0);
    req_valid = 2'b00;
    tick();
    reset = 1'b0;
    #1;
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_nz", 32'(rsp_nz), 0);
    check("rst_req_ready", 32'(req_ready), 0);

    // Table vectors: each runs one operation to completion from IDLE.
    for (int k = 0; k < 7; k++) begin
      set_req(0, vecs[k].a0, vecs[k].b0, vecs[k].op0);
      set_req(1, vecs[k].a1, vecs[k].b1, vecs[k].op1);
      req_valid = vecs[k].valid;
      #1;
      wait_grant($sformatf("vec%0d_grant", k), vecs[k].exp_id, 5);
      tick();
      req_valid = 2'b00;
      check($sformatf("vec%0d_alu_a", k), 32'(alu_a),
            32'(vecs[k].exp_id == 1 ? vecs[k].a1 : vecs[k].a0));
      check($sformatf("vec%0d_alu_b", k), 32'(alu_b),
            32'(vecs[k].exp_id == 1 ? vecs[k].b1 : vecs[k].b0));
      check($sformatf("vec%0d_alu_op", k), 32'(alu_op),
            32'(vecs[k].exp_id == 1 ? vecs[k].op1 : vecs[k].op0));
      expect_rsp($sformatf("vec%0d", k), vecs[k].exp_id, vecs[k].exp_data, vecs[k].exp_nz);
      tick();
      check($sformatf("vec%0d_drained", k), 32'(rsp_valid), 0);
    end

    // Contention: loser stays pending and is served on the next IDLE.
    do_reset();
    set_req(0, 10, 10, 1'b1);
    set_req(1, 2, 4, 1'b0);
    req_valid = 2'b11;
    #1;
    wait_grant("cont_first", 0, 5);
    tick();
    req_valid = 2'b10;
    expect_rsp("cont_r0", 0, 0, 1'b0);
    tick();
    wait_grant("cont_second", 1, 0);
    tick();
    req_valid = 2'b00;
    expect_rsp("cont_r1", 1, 6, 1'b1);
    tick();

    // Back-pressure: response held, req 1 waits until drain.
    set_req(0, 20, 7, 1'b0);
    set_req(1, 9, 4, 1'b1);
    req_valid = 2'b11;
    #1;
    wait_grant("bp_grant0", 0, 5);
    tick();
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    expect_rsp("bp_r0", 0, 27, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_id", 32'(rsp_id), 0);
      check("bp_hold_data", 32'(rsp_data), 27);
      check("bp_hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    wait_grant("bp_grant1", 1, 0);
    tick();
    req_valid = 2'b00;
    expect_rsp("bp_r1", 1, 5, 1'b1);
    tick();

    // Continuous contention alternates, then a lone requester gets every IDLE.
    do_reset();
    set_req(0, 1, 1, 1'b0);
    set_req(1, 2, 2, 1'b0);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      wait_grant($sformatf("alt%0d_grant", k), k % 2, (k == 0) ? 5 : 0);
      tick();
      expect_rsp($sformatf("alt%0d", k), k % 2, (k % 2 == 1) ? 4 : 2, 1'b1);
      tick();
    end
    req_valid = 2'b10;
    #1;
    for (int k = 0; k < 3; k++) begin
      wait_grant($sformatf("solo%0d_grant", k), 1, 0);
      tick();
      expect_rsp($sformatf("solo%0d", k), 1, 4, 1'b1);
      tick();
    end
    req_valid = 2'b00;

    // Reset during EXEC discards the operation.
    do_reset();
    set_req(0, 30, 40, 1'b0);
    req_valid = 2'b01;
    #1;
    wait_grant("rexec_grant", 0, 5);
    tick();
    req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check("rexec_rsp_valid", 32'(rsp_valid), 0);
    check("rexec_alu_a", 32'(alu_a), 0);
    check("rexec_alu_b", 32'(alu_b), 0);
    check("rexec_alu_op", 32'(alu_op), 0);
    check("rexec_req_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rexec_no_rsp", 32'(rsp_valid), 0);
    end
    set_req(0, 3, 3, 1'b1);
    set_req(1, 4, 4, 1'b0);
    req_valid = 2'b11;
    #1;
    wait_grant("rexec_post_grant", 0, 5);
    tick();
    req_valid = 2'b00;
    expect_rsp("rexec_post", 0, 0, 1'b0);
    tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_last  = 1;
    phase   = 0;
    granted = -1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (granted >= 0) begin
        pend[granted]      = 1'b0;
        req_valid[granted] = 1'b0;
        granted            = -1;
      end
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i]   = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MOD - 1 : 0)
                                                : int'($urandom_range(0, MOD - 1));
          pb[i]   = ($urandom_range(0, 3) == 0) ? pa[i] : int'($urandom_range(0, MOD - 1));
          pop[i]  = $urandom_range(0, 1) == 1;
          set_req(i, pa[i], pb[i], pop[i]);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      case (phase)
        0: begin
          if (pend[0] || pend[1]) begin
            w = pend[1 - m_last] ? 1 - m_last : m_last;
            check("rnd_grant", 32'(req_ready), 32'(1 << w));
            check("rnd_idle_rsp", 32'(rsp_valid), 0);
            m_id    = w;
            m_data  = ref_alu(pa[w], pb[w], pop[w]);
            m_nz    = (m_data != 0);
            m_last  = w;
            granted = w;
            phase   = 1;
          end else begin
            check("rnd_idle_ready", 32'(req_ready), 0);
          end
        end
        1: begin
          check("rnd_exec_ready", 32'(req_ready), 0);
          check("rnd_exec_rsp", 32'(rsp_valid), 0);
          phase = 2;
        end
        default: begin
          check("rnd_rsp_valid", 32'(rsp_valid), 1);
          check("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
          check("rnd_rsp_data", 32'(rsp_data), 32'(m_data));
          check("rnd_rsp_nz", 32'(rsp_nz), 32'(m_nz));
          check("rnd_rsp_req_ready", 32'(req_ready), 0);
          if (rsp_ready) phase = 0;
        end
      endcase
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU datapath between two requesters. It accepts operand/opcode requests over valid/ready handshakes and drives the ALU's A, B and OP inputs from registers. It captures the ALU result and zero flag, then returns a tagged response over a valid/ready handshake. It sits between the requesting controllers and the ALU, replacing the direct controller-to-ALU connection.

## Interface
- WIDTH, 7, operand/result width; must match the ALU
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high
- req_a  in  2*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  2*WIDTH  operand B, same packing
- req_op  in  2  opcode per requester; 0 = add, 1 = subtract (A-B), modulo 2^WIDTH
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_op  out  1  registered opcode to ALU
- alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_op
- alu_zf  in  1  ALU zero flag (1 when result == 0)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  index of the requester that issued the operation
- rsp_data  out  WIDTH  captured ALU result
- rsp_nz  out  1  captured ~alu_zf (result nonzero)

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick a winner by round-robin against last_grant. The winner is the requester not equal to last_grant if it is valid, else the other one.
  - req_ready[winner] = 1, combinational from state and req_valid.
  - On fire (valid & ready): latch that requester's a/b/op into alu_a/alu_b/alu_op, set last_grant = winner, latch the id, go to EXEC.
  - With no valid requests, stay in IDLE with req_ready = 0.
- EXEC:
  - ALU settles from the registered inputs.
  - At the end of the cycle, capture rsp_data = alu_result and rsp_nz = ~alu_zf, then go to RESP.
- RESP:
  - rsp_valid = 1 with rsp_id, rsp_data and rsp_nz held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - req_ready = 0 throughout RESP.
- alu_a/alu_b/alu_op hold their last values outside EXEC; no zeroing between operations.
- Requesters must hold req_* stable while req_valid is high until fire. req_valid must not depend on req_ready.
- Arithmetic is performed in the ALU and wraps modulo 2^WIDTH. The block does no width extension.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins first contention)
  - alu_a = 0, alu_b = 0, alu_op = 0
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_nz = 0
  - req_ready = 0 while reset is asserted
- Latency: request fire at cycle N → EXEC at N+1 → rsp_valid high at N+2.
- Throughput: one operation per 3 cycles when rsp_ready is held high.
- Simultaneous requests: the winner alternates on every grant. The losing request stays pending and is granted on the next IDLE.
- A single requester holding valid continuously is granted every IDLE (no dead cycles waiting on the other requester).
- Back-pressure: rsp_ready low holds RESP indefinitely. No new request is accepted until the response drains.
- Reset mid-operation: any in-flight operation and response are discarded. All outputs return to reset values immediately (asynchronously).

## Structure
- Package alu_arb_pkg:
  - WIDTH default constant
  - state enum {IDLE, EXEC, RESP}
  - opcode constants OP_ADD = 0, OP_SUB = 1
- Sub-module rr_arb2: two-input round-robin picker. Inputs are req[1:0] and last[0]; outputs are gnt[1:0] and a gnt_id. It is purely combinational. The last_grant register lives in alu_arbiter.
- The ALU itself is instantiated by the enclosing top level, not inside this block.

## Test plan
- Reset, then release: all outputs 0, req_ready = 0; first request from req 0 (a = 5, b = 3, op = 0) → rsp_valid 2 cycles after fire, rsp_data = 8, rsp_nz = 1, rsp_id = 0.
- Both valid on the same cycle: req 0 (10 - 10) and req 1 (2 + 4) → req 0 granted first, giving rsp_data = 0, rsp_nz = 0, rsp_id = 0. Then req 1 is granted, giving rsp_data = 6, rsp_id = 1.
- Wrap-around: a = 127, b = 1, op = 0 → rsp_data = 0, rsp_nz = 0. Then a = 0, b = 1, op = 1 → rsp_data = 127, rsp_nz = 1.
- Back-pressure: hold rsp_ready = 0 for 5 cycles with req 1 valid → rsp fields stable, req_ready = 0 throughout. On release, req 1 is granted in the next IDLE.
- Continuous contention over 6 grants → ids alternate 0, 1, 0, 1, 0, 1. With only req 1 valid, it is granted on every IDLE.
- Assert reset during EXEC → rsp_valid stays 0, alu_a/alu_b/alu_op = 0, no response emitted. After release, the first contention grants req 0.
